// File: rtl/cfu_output_packer_if.sv
// Byte-result, CPU command and response signals between the accelerator, the CPU
// side and the output packer.
interface cfu_output_packer_if #(
  parameter int unsigned ADDR_W = 6
);
  logic              clear;
  logic              res_valid;
  logic [7:0]        res_data;
  logic              res_last;
  logic              res_ready;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              rsp_valid;
  logic [31:0]       rsp_data;
  logic              rsp_ready;
  logic [ADDR_W:0]   count;
  logic              empty;

  modport master (
    output clear, res_valid, res_data, res_last, cmd_valid, rsp_ready,
    input  res_ready, cmd_ready, rsp_valid, rsp_data, count, empty
  );

  modport slave (
    input  clear, res_valid, res_data, res_last, cmd_valid, rsp_ready,
    output res_ready, cmd_ready, rsp_valid, rsp_data, count, empty
  );
endinterface

// File: rtl/cfu_output_packer.sv
// Packs accelerator result bytes little-endian into 32-bit words, buffers them in a
// block-RAM FIFO and returns them to the CPU through a command/response handshake.
module cfu_output_packer #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input logic               clk,
  input logic               rst,
  cfu_output_packer_if.slave bus
);
  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

  state_t            state;
  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] rd_addr;
  logic [1:0]        lane;
  logic [31:0]       pack;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              res_ready;
  logic              cmd_ready;
  logic              rsp_valid;
  logic [31:0]       rsp_data;

  logic              flush;
  logic              accept_byte;
  logic              push;
  logic              pop;
  logic [31:0]       byte_word;
  logic [31:0]       push_word;
  logic [CNT_W-1:0]  count_n;

  assign bus.count     = count;
  assign bus.empty     = empty;
  assign bus.res_ready = res_ready;
  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_data;

  // Lanes above the current one are always zero in pack, so OR-ing in the new byte
  // yields the zero-padded word for a short burst.
  assign flush       = rst | bus.clear;
  assign accept_byte = bus.res_valid & res_ready;
  assign push        = accept_byte & ((lane == 2'd3) | bus.res_last);
  assign pop         = bus.cmd_valid & cmd_ready;
  assign byte_word   = 32'(bus.res_data) << {lane, 3'b000};
  assign push_word   = pack | byte_word;
  assign count_n     = count + CNT_W'(push) - CNT_W'(pop);

  // Byte packer and write pointer.
  always_ff @(posedge clk) begin
    if (flush) begin
      lane   <= 2'd0;
      pack   <= 32'd0;
      wr_ptr <= '0;
    end else if (accept_byte) begin
      if (push) begin
        lane   <= 2'd0;
        pack   <= 32'd0;
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end else begin
        lane   <= lane + 2'd1;
        pack   <= push_word;
      end
    end
  end

  // FIFO storage; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_word;
    end
  end

  // Read FSM, occupancy tracking and registered status outputs.
  always_ff @(posedge clk) begin
    if (flush) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      rd_addr   <= '0;
      count     <= '0;
      empty     <= 1'b1;
      res_ready <= 1'b1;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'd0;
    end else begin
      count     <= count_n;
      empty     <= (count_n == '0);
      res_ready <= (count_n != CNT_W'(DEPTH));
      case (state)
        IDLE: begin
          if (pop) begin
            rd_addr   <= rd_ptr;
            rd_ptr    <= rd_ptr + ADDR_W'(1);
            cmd_ready <= 1'b0;
            state     <= READ;
          end else begin
            cmd_ready <= (count_n != '0);
          end
        end
        READ: begin
          rsp_data  <= mem[rd_addr];
          rsp_valid <= 1'b1;
          cmd_ready <= 1'b0;
          state     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= (count_n != '0);
            state     <= IDLE;
          end else begin
            cmd_ready <= 1'b0;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule
